// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants for the MIPS front end.
package cpu_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fifo.sv
// Prefetch FIFO of {inst, pc4} entries; flush wins over a same-cycle push or pop.
module if_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     valid,
  output fetch_entry_t             head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_pop  = pop && !flush && (count_q != '0);
    do_push = push && !flush && ((count_q != CW'(DEPTH)) || do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the head mux hides unwritten slots behind valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_comb begin
    count = count_q;
    valid = (count_q != '0);
    head  = valid ? mem_q[rd_ptr_q] : '{inst: NOP_INST, pc4: 32'h0};
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: one outstanding imem request, results queued
// with their PC+4 for decode; redirects flush the queue and drop in-flight data.
module if_prefetch
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        hold,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc4_out
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  addr_q, addr_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_valid;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;
  logic          push;
  logic          pop;
  logic [31:0]   redir_pc;
  logic [31:0]   addr_plus4;
  logic          room;
  logic          unused_redir_lsb;

  assign redir_pc         = {redirect_addr[31:2], 2'b00};
  assign unused_redir_lsb = ^redirect_addr[1:0];
  assign addr_plus4       = addr_q + 32'd4;
  // A redirect empties the queue at this edge, so it always leaves room.
  assign room             = redirect || (fifo_count < CW'(DEPTH));

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    pop        = fifo_valid && !hold && !redirect;
    push_entry = '{inst: imem_rdata, pc4: addr_plus4};
    case (state_q)
      IDLE: begin
        if (redirect) fetch_pc_d = redir_pc;
        if (room) begin
          state_d = WAIT;
          addr_d  = redirect ? redir_pc : fetch_pc_q;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          state_d = IDLE;
          if (redirect) begin
            fetch_pc_d = redir_pc;
          end else begin
            push       = 1'b1;
            fetch_pc_d = addr_plus4;
          end
        end else if (redirect) begin
          state_d    = DROP;
          fetch_pc_d = redir_pc;
        end
      end
      DROP: begin
        if (redirect) fetch_pc_d = redir_pc;
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .count     (fifo_count),
    .valid     (fifo_valid),
    .head      (fifo_head)
  );

  assign imem_req   = (state_q != IDLE);
  assign imem_addr  = addr_q;
  assign inst_valid = fifo_valid;
  assign inst_out   = fifo_head.inst;
  assign pc4_out    = fifo_head.pc4;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_if_prefetch;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        hold;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc4_out;

  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .hold          (hold),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .inst_valid    (inst_valid),
    .inst_out      (inst_out),
    .pc4_out       (pc4_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch stream as a queue of {inst, pc4} pairs
  typedef struct packed { logic [31:0] inst; logic [31:0] pc4; } ent_t;
  ent_t        mq[$];
  bit          m_req;
  logic [31:0] m_addr;
  bit          m_stale;
  logic [31:0] m_pc;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic model_edge();
    int          old_n;
    bit          old_pend;
    bit          acked;
    logic [31:0] ra;
    old_n    = mq.size();
    old_pend = m_req;
    if (!rst_n) begin
      mq.delete();
      m_req = 0; m_addr = 32'h0; m_stale = 0; m_pc = RESET_PC;
      return;
    end
    ra    = {redirect_addr[31:2], 2'b00};
    acked = m_req && imem_ack;
    if (redirect) begin
      mq.delete();
      m_pc = ra;
    end else if (mq.size() != 0 && !hold) begin
      void'(mq.pop_front());
    end
    if (acked) begin
      if (!m_stale && !redirect) begin
        mq.push_back(ent_t'{inst: imem_rdata, pc4: m_addr + 32'd4});
        m_pc = m_addr + 32'd4;
      end
      m_stale = 0;
      m_req   = 0;
    end else if (m_req && redirect) begin
      m_stale = 1;
    end
    if (!old_pend && (redirect || old_n < DEPTH)) begin
      m_req  = 1;
      m_addr = m_pc;
    end
  endtask

  task automatic check_model();
    chk("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) chk("imem_addr", imem_addr, m_addr);
    chk("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
    chk("inst_out", inst_out, (mq.size() != 0) ? mq[0].inst : 32'h0);
    chk("pc4_out", pc4_out, (mq.size() != 0) ? mq[0].pc4 : 32'h0);
  endtask

  // Memory responder: lat = cycles the request is held, including the ack cycle
  int lat_cfg  = 1;
  int lat      = 1;
  int wcnt     = 0;
  bit stray_en = 0;
  int acks_seen = 0;

  function automatic int pick_lat();
    return (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
  endfunction

  task automatic resp_drive();
    if (!rst_n) imem_ack = 1'b0;
    else if (imem_req) imem_ack = (wcnt + 1 >= lat);
    else imem_ack = stray_en && ($urandom_range(0, 9) == 0);
    imem_rdata = (imem_ack && imem_req) ? memw(imem_addr) : $urandom;
  endtask

  task automatic resp_edge();
    if (!rst_n) begin
      wcnt = 0; lat = pick_lat();
    end else if (imem_req && imem_ack) begin
      acks_seen++; wcnt = 0; lat = pick_lat();
    end else if (imem_req) begin
      wcnt++;
    end
  endtask

  task automatic run_cycle();
    resp_drive();
    @(negedge clk);
    check_model();
    model_edge();
    resp_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hold = 1'b0; redirect = 1'b0; redirect_addr = 32'h0;
    repeat (2) run_cycle();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rst_n, hold, redirect;
    logic [31:0] raddr;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] inst, pc4;
  } vec_t;

  vec_t vecs[16];
  bit   found;

  initial begin
    rst_n = 1'b0; hold = 1'b0; redirect = 1'b0; redirect_addr = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;

    //        rst hold redir raddr          ack rdata           req addr          vld inst           pc4
    vecs[0]  = '{0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,         0, 32'h0,          32'h0};
    vecs[1]  = '{1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,         0, 32'h0,          32'h0};
    vecs[2]  = '{1, 0, 0, 32'h0,          1, 32'hA000_0000,  1, 32'h0,         0, 32'h0,          32'h0};
    vecs[3]  = '{1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,         1, 32'hA000_0000,  32'h4};
    vecs[4]  = '{1, 0, 0, 32'h0,          1, 32'hA000_0004,  1, 32'h4,         0, 32'h0,          32'h0};
    vecs[5]  = '{1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,         1, 32'hA000_0004,  32'h8};
    vecs[6]  = '{1, 0, 0, 32'h0,          1, 32'hA000_0008,  1, 32'h8,         1, 32'hA000_0004,  32'h8};
    vecs[7]  = '{1, 0, 1, 32'hFFFF_FFFE,  0, 32'h0,          0, 32'h0,         1, 32'hA000_0008,  32'hC};
    vecs[8]  = '{1, 0, 0, 32'h0,          1, 32'h1234_5678,  1, 32'hFFFF_FFFC, 0, 32'h0,          32'h0};
    vecs[9]  = '{1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,         1, 32'h1234_5678,  32'h0};
    vecs[10] = '{1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0,         0, 32'h0,          32'h0};
    vecs[11] = '{1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0,         0, 32'h0,          32'h0};
    vecs[12] = '{0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0,         0, 32'h0,          32'h0};
    vecs[13] = '{0, 0, 0, 32'h0,          1, 32'hDEAD_BEEF,  0, 32'h0,         0, 32'h0,          32'h0};
    vecs[14] = '{1, 0, 0, 32'h0,          1, 32'hDEAD_BEEF,  0, 32'h0,         0, 32'h0,          32'h0};
    vecs[15] = '{1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0,         0, 32'h0,          32'h0};

    repeat (2) begin
      @(negedge clk);
      model_edge();
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 16; i++) begin
      rst_n = vecs[i].rst_n; hold = vecs[i].hold; redirect = vecs[i].redirect;
      redirect_addr = vecs[i].raddr; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
      if (vecs[i].req) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_inst", i), inst_out, vecs[i].inst);
      chk($sformatf("vec%0d_pc4", i), pc4_out, vecs[i].pc4);
      model_edge();
      @(posedge clk);
      #1;
    end

    // Hold for many cycles: queue fills to DEPTH, then fetching stops
    lat_cfg = 1;
    do_reset();
    acks_seen = 0;
    hold = 1'b1;
    repeat (12) run_cycle();
    chk("hold_fill_acks", 32'(acks_seen), 32'(DEPTH));
    chk("hold_full_req", 32'(imem_req), 32'h0);
    hold = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (imem_req) found = 1;
      else run_cycle();
    end
    chk("resume_req_seen", 32'(found), 32'h1);
    if (found) chk("resume_addr", imem_addr, 32'h10);
    repeat (12) run_cycle();

    // Redirect while a 3-cycle request to 0x8 is outstanding
    lat_cfg = 3;
    do_reset();
    hold = 1'b1;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (imem_req && imem_addr == 32'h8) found = 1;
      else run_cycle();
    end
    chk("pend8_req_seen", 32'(found), 32'h1);
    redirect = 1'b1; redirect_addr = 32'h40;
    run_cycle();
    redirect = 1'b0; hold = 1'b0;
    chk("redir_flush_valid", 32'(inst_valid), 32'h0);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (inst_valid) found = 1;
      else run_cycle();
    end
    chk("redir_valid_seen", 32'(found), 32'h1);
    if (found) begin
      chk("redir_pc4", pc4_out, 32'h44);
      chk("redir_inst", inst_out, memw(32'h40));
    end
    repeat (8) run_cycle();

    // Redirect in the same cycle as an ack and a pop
    lat_cfg = 1;
    do_reset();
    hold = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (imem_req && inst_valid) found = 1;
      else run_cycle();
    end
    chk("ackpop_setup_seen", 32'(found), 32'h1);
    hold = 1'b0; redirect = 1'b1; redirect_addr = 32'h100;
    run_cycle();
    redirect = 1'b0;
    chk("ackpop_flush_valid", 32'(inst_valid), 32'h0);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (imem_req) found = 1;
      else run_cycle();
    end
    chk("ackpop_req_seen", 32'(found), 32'h1);
    if (found) chk("ackpop_addr", imem_addr, 32'h100);
    repeat (6) run_cycle();

    // Randomized traffic with random latency, stray acks and occasional reset
    lat_cfg = 0;
    stray_en = 1;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      hold     = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 24) == 0);
      redirect_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Instruction-fetch front end for the five-stage MIPS pipeline. It sits upstream of the decode stage and replaces the direct PC-to-instruction-memory path.
- Owns the fetch PC and issues word requests to an instruction memory with variable latency.
- Buffers returned instructions, paired with their PC+4, in a small prefetch FIFO that the decode stage drains.
- Honours decode stalls (hold) and taken-branch/jump redirects (flush).

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, range 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  byte address of the word requested; bits [1:0] always 0.
- imem_ack  in  1  request complete; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- hold  in  1  decode stall (stall_s1_s2); head entry is not consumed.
- redirect  in  1  taken branch or jump from MEM (pcsrc | jump_s4).
- redirect_addr  in  32  target address (baddr_s4 or jaddr_s4).
- inst_valid  out  1  head entry valid.
- inst_out  out  32  head instruction; 32'h0 (nop) when inst_valid=0.
- pc4_out  out  32  head PC+4; 32'h0 when inst_valid=0.

Behaviour:
- Reset (rst_n=0 at posedge):
  - fetch_pc=RESET_PC; FIFO emptied (count=0); pending=0; stale=0.
  - Outputs: imem_req=0, inst_valid=0, inst_out=0, pc4_out=0.
  - Reset during an outstanding request abandons it. Any imem_ack arriving while pending=0 is ignored.
- Request rule:
  - imem_req=1 when pending=0, count<DEPTH and rst_n=1. It is registered: it rises in the cycle after the condition holds.
  - Once raised, imem_req and imem_addr stay stable until a cycle with imem_ack=1. No retraction, including on redirect.
  - Only one request may be outstanding at a time.
- Completion: on a cycle with imem_req & imem_ack:
  - If stale=0 and redirect=0: push {imem_rdata, imem_addr+4} and set fetch_pc=imem_addr+4.
  - Otherwise discard the data and clear stale.
  - imem_req may rise again in the next cycle, giving one fetch per 2 cycles with zero-wait memory. The room check counts the entry just pushed.
- Output: inst_valid = (count != 0); inst_out/pc4_out show the head entry. inst_out/pc4_out are registered or muxed from the FIFO and never show X.
- Pop: at a posedge with inst_valid=1, hold=0 and redirect=0.
- Simultaneous push and pop: count unchanged; ordering preserved.
- Full (count==DEPTH): no new request. A pop frees room, and the request rises the cycle after.
- Empty with hold=0: inst_valid=0 and a nop is presented; decode sees a bubble.
- Redirect (highest priority, same posedge):
  - FIFO is flushed (count=0) and fetch_pc=redirect_addr.
  - If a request is outstanding and not acked in this cycle, stale=1; its data is dropped when it arrives.
  - The first request to redirect_addr rises the cycle after the redirect, or the cycle after the stale ack.
  - redirect overrides hold.
- Pointer and address arithmetic:
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
  - PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - redirect_addr[1:0] is forced to 0.

Decomposition:
- Shared package (cpu_pkg) holds:
  - NOP_INST=32'h0 and RESET_PC default.
  - FIFO entry typedef {inst[31:0], pc4[31:0]}.
- One sub-module, if_fifo: a synchronous DEPTH x 64 FIFO with push, pop, flush, count, head outputs and a flush-over-push priority.
- Fetch-control FSM stays in if_prefetch.
- Fetch-control states: IDLE (pending=0), WAIT (pending=1, stale=0), DROP (pending=1, stale=1).

Test Plan:
- Reset then zero-wait memory (ack same cycle as req), hold=0:
  - imem_addr sequence 0,4,8,...
  - inst_out stream equals memory words in order, with pc4_out 4,8,12.
  - No beat lost or duplicated.
- Memory latency 3 cycles:
  - imem_req/imem_addr held stable 3 cycles per request.
  - inst_valid pulses once per return.
- hold=1 for 10 cycles, DEPTH=4:
  - Exactly 4 entries fill, then imem_req stays 0.
  - On hold=0, entries drain in order and fetching resumes at address 16.
- redirect to 32'h40 while a 3-cycle request to 0x8 is pending:
  - FIFO empty next cycle; the 0x8 data is dropped.
  - Next request addr=0x40, next valid inst has pc4_out=0x44.
- redirect in the same cycle as an ack and a pop:
  - Acked data discarded, FIFO flushed, no pop side effect.
  - Next fetch at redirect_addr.
- rst_n=0 mid-request, then ack arrives after reset release:
  - Ack ignored; first request addr=RESET_PC.
  - All outputs 0 during reset.
- redirect_addr=32'hFFFF_FFFC:
  - Fetch at 0xFFFF_FFFC gives pc4_out=0, next fetch at 0.
